// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - round-robin scheduler for the shared routing-table memory port
// Grants the port to one client job at a time, sequences en/done and muxes its memory controls.
module mem_port_sched #(
  parameter int NCLI    = 3,
  parameter int ADDR_W  = 11,
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clock,
  input  logic                     nrst,
  input  logic [NCLI-1:0]          req,
  output logic [NCLI-1:0]          ack,
  output logic                     ack_err,
  output logic                     busy,
  output logic [1:0]               owner,
  output logic [NCLI-1:0]          cli_en,
  input  logic [NCLI-1:0]          cli_done,
  input  logic [NCLI*ADDR_W-1:0]   cli_addr,
  input  logic [NCLI-1:0]          cli_wr_en,
  input  logic [NCLI*WORD_W-1:0]   cli_wdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wr_en,
  output logic [WORD_W-1:0]        mem_wdata
);

  typedef enum logic [2:0] {IDLE, GRANT, RUN, DONE, ABORT} state_t;

  localparam logic [1:0]  LAST    = 2'(NCLI - 1);
  localparam logic [15:0] WDT_MAX = 16'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [15:0]       wdt;
  logic [1:0]        pick;
  logic [NCLI-1:0]   pick_oh;
  logic [NCLI-1:0]   owner_oh;
  logic              owner_done;
  logic [2*NCLI-1:0] req_dbl;
  logic [NCLI-1:0]   req_rot;
  logic [2:0]        sum;

  // Rotate req so rr_ptr sits at bit 0; the lowest set bit is the next owner.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NCLI-1:0];
    pick    = 2'd0;
    sum     = 3'd0;
    for (int k = NCLI - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, rr_ptr} + 3'(k);
        if (sum >= 3'(NCLI)) sum = sum - 3'(NCLI);
        pick = sum[1:0];
      end
    end
    for (int i = 0; i < NCLI; i++) begin
      pick_oh[i]  = (pick == 2'(i));
      owner_oh[i] = (owner == 2'(i));
    end
    owner_done = |(cli_done & owner_oh);
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (state == GRANT || state == RUN) begin
      for (int i = 0; i < NCLI; i++) begin
        if (owner_oh[i]) begin
          mem_addr  = cli_addr[i*ADDR_W +: ADDR_W];
          mem_wdata = cli_wdata[i*WORD_W +: WORD_W];
          mem_wr_en = cli_wr_en[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      rr_ptr  <= 2'd0;
      owner   <= 2'd0;
      wdt     <= 16'd0;
      ack     <= '0;
      ack_err <= 1'b0;
      busy    <= 1'b0;
      cli_en  <= '0;
    end else begin
      ack     <= '0;
      ack_err <= 1'b0;
      cli_en  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner  <= pick;
            wdt    <= 16'd0;
            cli_en <= pick_oh;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        // Done is not looked at here: it may still be high from the client's previous job.
        GRANT: state <= RUN;
        RUN: begin
          wdt <= wdt + 16'd1;
          if (owner_done) begin
            ack   <= owner_oh;
            state <= DONE;
          end else if (wdt == WDT_MAX) begin
            ack     <= owner_oh;
            ack_err <= 1'b1;
            state   <= ABORT;
          end
        end
        DONE, ABORT: begin
          rr_ptr <= (owner == LAST) ? 2'd0 : owner + 2'd1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - randomized job-level bench for mem_port_sched
// Bench acts as upstream controller and all clients; a round-robin job model predicts each grant.
module tb_mem_port_sched;

  localparam int NCLI = 3;
  localparam int AW   = 11;
  localparam int WW   = 16;
  localparam int TO   = 16;

  logic              clock = 1'b0;
  logic              nrst  = 1'b0;
  logic [NCLI-1:0]   req;
  logic [NCLI-1:0]   ack;
  logic              ack_err;
  logic              busy;
  logic [1:0]        owner;
  logic [NCLI-1:0]   cli_en;
  logic [NCLI-1:0]   cli_done;
  logic [NCLI*AW-1:0] cli_addr;
  logic [NCLI-1:0]   cli_wr_en;
  logic [NCLI*WW-1:0] cli_wdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en;
  logic [WW-1:0]     mem_wdata;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;

  mem_port_sched #(.NCLI(NCLI), .ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO)) dut (
    .clock(clock), .nrst(nrst), .req(req), .ack(ack), .ack_err(ack_err),
    .busy(busy), .owner(owner), .cli_en(cli_en), .cli_done(cli_done),
    .cli_addr(cli_addr), .cli_wr_en(cli_wr_en), .cli_wdata(cli_wdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Randomize every client's bus; done levels change for everyone except 'keep'.
  task automatic shake(input int keep);
    cli_addr  = (NCLI*AW)'({$urandom(), $urandom()});
    cli_wdata = (NCLI*WW)'({$urandom(), $urandom()});
    cli_wr_en = NCLI'($urandom());
    for (int i = 0; i < NCLI; i++)
      if (i != keep) cli_done[i] = 1'($urandom());
  endtask

  task automatic check_mux(input bit active, input int own);
    if (active) begin
      check_eq("mem_addr",  32'(mem_addr),  32'(cli_addr[own*AW +: AW]));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(cli_wdata[own*WW +: WW]));
      check_eq("mem_wr_en", 32'(mem_wr_en), 32'(cli_wr_en[own]));
    end else begin
      check_eq("mem_addr_idle",  32'(mem_addr),  32'd0);
      check_eq("mem_wdata_idle", 32'(mem_wdata), 32'd0);
      check_eq("mem_wr_en_idle", 32'(mem_wr_en), 32'd0);
    end
  endtask

  function automatic int next_owner(input logic [NCLI-1:0] r, input int ptr);
    for (int k = 0; k < NCLI; k++)
      if (r[(ptr + k) % NCLI]) return (ptr + k) % NCLI;
    return -1;
  endfunction

  initial begin
    int eo, d, c;
    bit err;
    logic [NCLI-1:0] r;

    req = '0; cli_done = '0; cli_wr_en = '0; cli_addr = '0; cli_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    cli_wr_en = '1;
    #1;
    check_eq("rst_busy",    32'(busy),      32'd0);
    check_eq("rst_ack",     32'(ack),       32'd0);
    check_eq("rst_ack_err", 32'(ack_err),   32'd0);
    check_eq("rst_cli_en",  32'(cli_en),    32'd0);
    check_eq("rst_owner",   32'(owner),     32'd0);
    check_eq("rst_wr_en",   32'(mem_wr_en), 32'd0);
    @(negedge clock) nrst = 1'b1;
    step;

    for (int j = 0; j < 70; j++) begin
      // Current cycle: DUT is in IDLE.
      if (j > 5 && $urandom_range(0, 3) == 0) begin
        req = '0;
        shake(-1);
        #1 check_mux(1'b0, 0);
        step;
        check_eq("gap_busy",   32'(busy),   32'd0);
        check_eq("gap_cli_en", 32'(cli_en), 32'd0);
      end
      if (j < 4)       r = 3'b111;
      else if (j == 4) r = 3'b101;
      else             r = NCLI'($urandom_range(1, 7));
      if (j == 0)      d = 9;
      else if (j == 1) d = TO - 1;
      else if (j == 2) d = 1000;
      else             d = $urandom_range(0, TO + 3);
      eo = next_owner(r, rr_m);
      req = r;
      shake(-1);
      #1 check_mux(1'b0, 0);
      step;
      check_eq("grant_cli_en", 32'(cli_en), 32'(1 << eo));
      check_eq("grant_owner",  32'(owner),  32'(eo));
      check_eq("grant_busy",   32'(busy),   32'd1);
      check_eq("grant_ack",    32'(ack),    32'd0);
      shake(eo);
      #1 check_mux(1'b1, eo);
      cli_done[eo] = 1'b0;
      req = NCLI'($urandom());
      step;
      c = 0;
      err = 1'b1;
      while (c < TO) begin
        check_eq("run_busy",   32'(busy),   32'd1);
        check_eq("run_ack",    32'(ack),    32'd0);
        check_eq("run_cli_en", 32'(cli_en), 32'd0);
        shake(eo);
        cli_done[eo] = 1'b0;
        #1 check_mux(1'b1, eo);
        req = NCLI'($urandom());
        if (c == d) begin
          cli_done[eo] = 1'b1;
          err = 1'b0;
        end
        if (c == d || c == TO - 1) break;
        c++;
        step;
      end
      step;
      check_eq("end_ack",     32'(ack),     32'(1 << eo));
      check_eq("end_ack_err", 32'(ack_err), 32'(err));
      check_eq("end_busy",    32'(busy),    32'd1);
      shake(eo);
      cli_wr_en = '1;
      #1 check_mux(1'b0, 0);
      rr_m = (eo + 1) % NCLI;
      step;
      check_eq("idle_busy",    32'(busy),    32'd0);
      check_eq("idle_ack",     32'(ack),     32'd0);
      check_eq("idle_ack_err", 32'(ack_err), 32'd0);
    end

    // Reset while the owner is writing.
    req = 3'b010;
    shake(1);
    step;
    check_eq("rg_cli_en", 32'(cli_en), 32'b010);
    cli_done[1] = 1'b0;
    step;
    cli_wr_en = '1;
    #1 check_eq("rr_wr_en", 32'(mem_wr_en), 32'd1);
    nrst = 1'b0;
    #1;
    check_eq("async_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("async_busy",  32'(busy),      32'd0);
    req = '0;
    @(negedge clock) nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check_eq("post_rst_ack",  32'(ack),  32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
    end
    req = 3'b111;
    step;
    check_eq("post_rst_owner", 32'(owner),  32'd0);
    check_eq("post_rst_en",    32'(cli_en), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Scheduler and arbiter for the single shared routing-table memory port (11-bit address, 16-bit word). It sits between an upstream controller and up to NCLI memory-walking client FSMs (cost learning, packet forwarding, reward update), each started by a one-cycle `en` and finishing with a level `done`. It grants the port to one client at a time in round-robin order and sequences that client's en/done handshake. It muxes the owner's address and write controls onto the memory, and releases the port when the client reports done or when a watchdog timeout expires.

## Interface
- NCLI, 3, number of clients (2..4)
- ADDR_W, 11, memory address width
- WORD_W, 16, memory word width
- TIMEOUT, 4096, maximum RUN cycles before forced release (2..65535)
- clock  in  1  sole clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- req  in  NCLI  level job request per client, from upstream controller
- ack  out  NCLI  one-cycle pulse: job for client i finished or aborted
- ack_err  out  1  high with ack when release was a timeout
- busy  out  1  port owned (GRANT/RUN/DONE/ABORT)
- owner  out  2  index of current/last owner
- cli_en  out  NCLI  one-cycle start pulse to client i
- cli_done  in  NCLI  client done levels
- cli_addr  in  NCLI*ADDR_W  packed client addresses, client i at [i*ADDR_W +: ADDR_W]
- cli_wr_en  in  NCLI  client write enables
- cli_wdata  in  NCLI*WORD_W  packed client write data
- mem_addr  out  ADDR_W  to memory
- mem_wr_en  out  1  to memory
- mem_wdata  out  WORD_W  to memory
- Memory read data fans out to all clients directly; it is not routed through this block.

## Operation
- States: IDLE, GRANT, RUN, DONE, ABORT.
- IDLE: sample req. If any bit is set, pick the first set bit scanning upward from rr_ptr with wrap. Latch it into owner, clear wdt, go to GRANT.
- GRANT: cli_en[owner]=1 for this cycle only; next state is RUN.
- RUN: wdt increments every cycle.
  - cli_done[owner]=1 → DONE.
  - Otherwise, if wdt == TIMEOUT-1 → ABORT.
  - Otherwise stay in RUN.
- DONE: ack[owner]=1, ack_err=0, rr_ptr=owner+1 (mod NCLI) → IDLE.
- ABORT: ack[owner]=1, ack_err=1, rr_ptr=owner+1 (mod NCLI) → IDLE.
- Memory mux:
  - In GRANT and RUN: mem_addr=cli_addr[owner], mem_wdata=cli_wdata[owner], mem_wr_en=cli_wr_en[owner] (combinational from state/owner).
  - In all other states: mem_wr_en=0, mem_addr=0, mem_wdata=0.
- cli_done is ignored during GRANT. A client's done is still high from its previous job until it sees en, so it must not be taken as completion.
- cli_done of non-owners is ignored in all states.
- Owner dropping req mid-job: ignored; the job runs to DONE or ABORT.
- req is sampled only in IDLE. A requester that keeps req high after its ack is rescheduled, taking its round-robin turn behind the other pending clients.
- done and timeout in the same RUN cycle: done wins, so ack_err=0.
- No abort signal goes to the client. After ABORT the port is simply reassigned, and the client's writes are blocked by the mux.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=0; owner=0; wdt=0.
  - ack=0, ack_err=0, busy=0, cli_en=0.
  - mem_wr_en=0 immediately, with no clock needed.
- Reset mid-RUN: the write is cut off the same instant. After release, no ack is issued for the interrupted job.
- Latency: req seen in IDLE cycle 0 → cli_en in cycle 1 → done sampled from cycle 2 on.
  - Done first seen in cycle k → ack in cycle k+1 → IDLE in cycle k+2.
  - The earliest next cli_en is cycle k+3.
- Timeout: with no done, RUN lasts exactly TIMEOUT cycles. ack/ack_err come in the following cycle.
- All outputs except the memory mux are registered state decodes.
- busy=1 from the GRANT cycle through the DONE/ABORT cycle inclusive.

## Test plan
- Single job: req=001, client 0 pulses done 10 cycles after en → cli_en[0] for 1 cycle; mem_* follow client 0 only in GRANT/RUN; ack=001 one cycle after done with ack_err=0; busy low 2 cycles after done.
- Stale done: client 1 holds done=1 from a prior job and lowers it the cycle after en → no early ack; ack only after the new done rises.
- Round robin: req=111 held, each client done after 5 cycles → grant order 0,1,2,0; with req=101 after owner 0, next owner is 2.
- Timeout with TIMEOUT=16: client never asserts done → RUN lasts 16 cycles, then ack with ack_err=1; mem_wr_en=0 afterwards even while cli_wr_en is held high.
- Contention: non-owner asserts cli_wr_en=1 and cli_addr=0x68A during another client's RUN → mem_wr_en and mem_addr reflect the owner only; done and timeout in the same cycle → ack_err=0.
- Reset mid-RUN, owner writing → mem_wr_en drops asynchronously; after release busy=0, rr_ptr=0, and no ack is issued.
